// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scanning path: blank code and
// scanner FSM state type.
package ssd_pkg;

    localparam logic [3:0] SSD_BLANK_CODE = 4'hF;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/ssd_scan_tick.sv
// Slot counter for ssd_scan: counts 0..REFRESH_DIV-1 and flags slot start,
// end of the guard interval and the wrap cycle.
module ssd_scan_tick
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start,
    output logic guard_done,
    output logic slot_wrap
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_C  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_C) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign slot_start = (r_cnt == '0);
    assign guard_done = (r_cnt == GUARD_C);
    assign slot_wrap  = (r_cnt == LAST_C);

endmodule

// File: rtl/ssd_scan.sv
// Multiplexed digit scanner feeding the ssd decoder. Optional leading-zero
// suppression is enabled by defining SSD_SCAN_LZ_SUPPRESS_EN.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [4*NUM_DIGITS-1:0]                            value,
    input  logic                                               load,
    input  logic                                               blank,
    output logic [3:0]                                         digit_data,
    output logic [NUM_DIGITS-1:0]                              digit_en,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] r_shadow;
    logic [IW-1:0]              r_idx;
    scan_state_e                r_state;
    scan_state_e                w_state_nxt;
    logic                       w_slot_start;
    logic                       w_guard_done;
    logic                       w_slot_wrap;
    logic [3:0]                 w_sample;
    logic [3:0]                 w_data_nxt;
    logic [NUM_DIGITS-1:0]      w_en_nxt;

    ssd_scan_tick #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_start(w_slot_start),
        .guard_done(w_guard_done),
        .slot_wrap (w_slot_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= {NUM_DIGITS{SSD_BLANK_CODE}};
        end else if (load) begin
            r_shadow <= value;
        end
    end

    // Internal index runs one cycle ahead of the outputs: it advances on the
    // counter wrap so the slot-start edge samples the new digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_slot_wrap) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        end
    end

`ifdef SSD_SCAN_LZ_SUPPRESS_EN
    logic w_lz;

    always_comb begin
        w_lz = (r_idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(r_idx) && r_shadow[k] != 4'h0) begin
                w_lz = 1'b0;
            end
        end
        w_sample = w_lz ? SSD_BLANK_CODE : r_shadow[r_idx];
    end
`else
    always_comb begin
        w_sample = r_shadow[r_idx];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GUARD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A slot start that is also the guard end means a zero-length guard.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = digit_data;
        w_en_nxt    = '0;
        case (r_state)
            GUARD: if (w_guard_done) w_state_nxt = DRIVE;
            DRIVE: if (w_slot_start && !w_guard_done) w_state_nxt = GUARD;
            default: w_state_nxt = GUARD;
        endcase
        if (w_slot_start) begin
            w_data_nxt = w_sample;
        end
        if (w_state_nxt == DRIVE && !blank) begin
            w_en_nxt = NUM_DIGITS'(1) << r_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_data <= SSD_BLANK_CODE;
            digit_en   <= '0;
            digit_idx  <= '0;
        end else begin
            digit_data <= w_data_nxt;
            digit_en   <= w_en_nxt;
            digit_idx  <= r_idx;
        end
    end

endmodule

// File: doc/ssd_scan.md
# ssd_scan

Time-multiplexed digit scanner that sits directly upstream of the seven-segment decoder `ssd`. It captures a packed multi-digit BCD value, cycles through the digits at a programmable refresh rate, and presents one 4-bit digit code per slot to `ssd` along with a one-hot digit enable for the common-electrode drivers. A guard interval at the start of each slot suppresses ghosting between digits.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 1.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD_CYCLES`, default 16: cycles at the start of each slot with all enables off; must be < `REFRESH_DIV`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `value` input, 4*NUM_DIGITS bits: packed digits; digit 0 is `value[3:0]` and is the least significant.
- `load` input, 1 bit: capture `value` into the shadow register on this edge.
- `blank` input, 1 bit: force all enables off while high; scanning continues.
- `digit_data` output, 4 bits: code for the current digit, fed to `ssd.data`.
- `digit_en` output, NUM_DIGITS bits: active-high one-hot enable for the current digit.
- `digit_idx` output, $clog2(NUM_DIGITS) bits (minimum 1): index of the current slot.

## Operation
- Shadow register: loads `value` on any edge where `load`=1; otherwise holds. Reset value is all 4'hF, which `ssd` decodes to all segments off.
- Slot counter runs from 0 to REFRESH_DIV-1 and then wraps. On wrap, `digit_idx` advances, wrapping from NUM_DIGITS-1 to 0.
- FSM states:
  - GUARD: counter below GUARD_CYCLES.
  - DRIVE: counter at or above GUARD_CYCLES.
  - Transitions: GUARD→DRIVE when counter reaches GUARD_CYCLES; DRIVE→GUARD on slot wrap. With GUARD_CYCLES=0, GUARD is never entered after reset exits.
- `digit_data` is sampled from the shadow nibble `[idx]` on the slot-start edge and held constant for the whole slot.
  - A `load` on that same edge is not seen until the next slot: the sample uses the pre-load shadow.
- `digit_en` equals `1 << digit_idx` only in DRIVE with `blank`=0; otherwise it is 0.
- `blank` has no effect on the counter, the index or `digit_data`.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Reset values:
  - `digit_en`=0, `digit_data`=4'hF, `digit_idx`=0.
  - Slot counter=0, state GUARD.
- After reset release, the first slot-start sample happens at the first rising edge.
- Per slot, in cycles: GUARD_CYCLES with enables off, then REFRESH_DIV-GUARD_CYCLES with the enable on. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Latency:
  - `load` to visible data: at most NUM_DIGITS slot boundaries.
  - `blank` assert or deassert to `digit_en` change: 1 cycle.
- Reset mid-slot: all outputs return to their reset values immediately (asynchronous); the shadow register is cleared to 4'hF.

## Configuration
- `SSD_SCAN_LZ_SUPPRESS_EN`:
  - Defined: leading-zero suppression. When the shadow nibble for the sampled index is 0 and every higher-index nibble is 0, `digit_data` is 4'hF.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - Undefined: shadow nibbles pass through unchanged.

## Structure
- Shared package `ssd_pkg`:
  - `SSD_BLANK_CODE` = 4'hF.
  - FSM state typedef (GUARD, DRIVE).
- Sub-module `ssd_scan_tick`: slot counter parameterised by REFRESH_DIV. It outputs `slot_start` (counter==0) and `guard_done` (counter==GUARD_CYCLES).
- The top level holds the shadow register, digit index, FSM, output registers and the optional leading-zero logic.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset then load `value`=16'h1234:
  - Per slot, `digit_en` is 0 for 2 cycles, then 0001/0010/0100/1000 for 6 cycles each.
  - `digit_data` is 4,3,2,1 in those slots; the frame repeats every 32 cycles.
- `load` 16'h5678 on a slot-start edge while idx=1: that slot still shows 3, and idx=2 shows 6.
- `blank`=1 for 10 cycles mid-DRIVE: `digit_en`=0 from the next edge. The index keeps advancing on schedule, and the enable resumes 1 cycle after `blank` falls.
- `rst_n` pulsed low mid-DRIVE on idx=2: outputs are 0/4'hF/0 immediately. After release, the display shows 4'hF on all digits until the next `load`.
- With `SSD_SCAN_LZ_SUPPRESS_EN`:
  - `value`=16'h0050 gives data 0,5,F,F.
  - `value`=16'h0000 gives 0,F,F,F.
- Without the macro, `value`=16'h0050 gives 0,5,0,0.
